instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words with their PCs and hands them to
// decode. Taken-branch redirects flush the buffer and drop wrong-path returns.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       ins_word,
    output logic [5:0]        ins_op,
    output logic [5:0]        ins_funct,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, rsp_pc, redirect_target;
    logic [CNT_W-1:0]  outstanding, outstanding_next;
    logic [CNT_W-1:0]  discard, discard_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              redir_q;
    logic              req_hs, rsp_hit, redir, push, pop;

    logic [31:0]       fifo_word [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];

    // Handshake qualifiers; a response with nothing outstanding is ignored.
    assign req_hs          = imem_req_valid && imem_req_ready;
    assign rsp_hit         = imem_rsp_valid && (outstanding != '0);
    assign redir           = redirect_valid && (state != BOOT);
    assign push            = rsp_hit && !redir && (discard == '0);
    assign pop             = ins_valid && ins_ready;
    assign redirect_target = redirect_pc & ~ADDR_W'(3);

    assign occupancy        = {1'b0, outstanding} + {1'b0, count};
    assign outstanding_next = outstanding + CNT_W'(req_hs) - CNT_W'(rsp_hit);

    // Requests stop while the buffer plus in-flight slots are full and for one
    // cycle after any redirect, so the address never changes under valid.
    assign imem_req_valid = (state == RUN) && !redir_q && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = pc;

    assign ins_valid = (count != '0);
    assign ins_word  = ins_valid ? fifo_word[rd_ptr] : '0;
    assign ins_pc    = ins_valid ? fifo_pc[rd_ptr]   : '0;
    assign ins_op    = ins_word[31:26];
    assign ins_funct = ins_word[5:0];

    // Next-state, next-PC and discard bookkeeping; redirect overrides all.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        case (state)
            BOOT:  state_next = RUN;
            RUN: begin
                if (req_hs) pc_next = pc + ADDR_W'(4);
            end
            DRAIN: begin
                if (rsp_hit) discard_next = discard - CNT_W'(1);
                if (discard_next == '0) state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
        if (redir) begin
            pc_next      = redirect_target;
            discard_next = outstanding_next;
            state_next   = (outstanding_next != '0) ? DRAIN : RUN;
        end
    end

    // Control state, counters and FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            redir_q     <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            redir_q     <= redir;
            if (redir) begin
                rsp_pc <= redirect_target;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    rsp_pc <= rsp_pc + ADDR_W'(4);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Buffer storage for returned words and their PCs.
    // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model
// and a scoreboard of expected decode-side PCs.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ins_valid, ins_ready;
    logic [31:0] ins_word, ins_pc;
    logic [5:0]  ins_op, ins_funct;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int mem_lat = 1;
    bit mem_hold = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    int          mem_t[$];

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
        .ins_op(ins_op), .ins_funct(ins_funct), .ins_pc(ins_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // One clock: score decode handshakes and memory traffic before the edge,
    // then drive the next memory response after it.
    task automatic tick();
        logic [31:0] e, w;
        @(negedge clk);
        if (ins_valid && ins_ready) begin
            if (exp_q.size() == 0) begin
                check("ins_unexpected", 32'(ins_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                w = e | 32'h8C00_0000;
                check("ins_pc", ins_pc, e);
                check("ins_word", ins_word, w);
                check("ins_op", 32'(ins_op), 32'(w[31:26]));
                check("ins_funct", 32'(ins_funct), 32'(w[5:0]));
            end
        end
        if (imem_rsp_valid) begin
            mem_q.delete(0);
            mem_t.delete(0);
        end
        if (redirect_valid) exp_q.delete();
        if (rst_n && imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            mem_t.push_back(cyc);
            if (!redirect_valid) exp_q.push_back(imem_req_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!mem_hold && mem_q.size() > 0 && cyc >= mem_t[0] + mem_lat) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0] | 32'h8C00_0000;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req_valid && n < 30) begin
            tick();
            n++;
        end
        if (!imem_req_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        int k;
        bit seen;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        ins_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_ins_word", ins_word, 32'h0);
        check("rst_ins_pc", ins_pc, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Boot and sequential fetch
        check("boot_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        k = 1;
        while (!ins_valid && k < 20) begin
            tick();
            k++;
        end
        check("first_valid_cycle", 32'(k), 32'd3);
        tick();

        // Decode stall
        ins_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_ins_valid", 32'(ins_valid), 32'd1);
        check("stall_inflight", 32'(exp_q.size()), 32'd2);
        ins_ready = 1'b1;

        // Memory backpressure on the request for 0x10
        k = 0;
        while (!(imem_req_valid && imem_req_addr == 32'h10) && k < 30) begin
            tick();
            k++;
        end
        check("bp_reach_0x10", 32'(imem_req_valid && imem_req_addr == 32'h10), 32'd1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", 32'(imem_req_valid), 32'd1);
            check("bp_addr_held", imem_req_addr, 32'h10);
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Redirect with two requests in flight
        mem_hold = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("pre_redir_inflight", 32'(mem_q.size()), 32'd2);
        check("pre_redir_req_valid", 32'(imem_req_valid), 32'd0);
        do_redirect(32'h103);
        mem_hold = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!imem_req_valid && k < 30) begin
            if (ins_valid) seen = 1'b1;
            tick();
            k++;
        end
        check("drain_no_ins_valid", 32'(seen), 32'd0);
        check("drain_done_inflight", 32'(mem_q.size()), 32'd0);
        check("redir_req_addr", imem_req_addr, 32'h100);
        k = 0;
        while (!ins_valid && k < 30) begin
            tick();
            k++;
        end
        check("redir_first_pc", ins_pc, 32'h100);
        for (int i = 0; i < 4; i++) tick();

        // Redirect coinciding with a request handshake and a response
        k = 0;
        while (!(imem_req_valid && imem_req_ready && imem_rsp_valid) && k < 30) begin
            tick();
            k++;
        end
        check("coincide_reached", 32'(imem_req_valid && imem_rsp_valid), 32'd1);
        do_redirect(32'h200);
        wait_req("coincide_req");
        check("coincide_req_addr", imem_req_addr, 32'h200);
        k = 0;
        while (!ins_valid && k < 30) begin
            tick();
            k++;
        end
        check("coincide_first_pc", ins_pc, 32'h200);
        for (int i = 0; i < 4; i++) tick();

        // PC wrap at the top of the address space
        do_redirect(32'hFFFF_FFFC);
        wait_req("wrap_req");
        check("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        wait_req("wrap_next");
        check("wrap_zero_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 6; i++) tick();

        // Asynchronous reset in the middle of a drain
        mem_hold = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        do_redirect(32'h300);
        tick();
        check("drain_req_off", 32'(imem_req_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_ins_valid", 32'(ins_valid), 32'd0);
        check("arst_ins_word", ins_word, 32'h0);
        check("arst_ins_pc", ins_pc, 32'h0);
        mem_q.delete();
        mem_t.delete();
        exp_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mem_hold = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wait_req("restart_req");
        check("restart_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 8; i++) tick();

        // Quiesce: nothing lost, nothing duplicated
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("end_mem_empty", 32'(mem_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
